// File: rtl/serial_to_parallel_pkg.sv
// Shared constants and bit-placement helpers for the serial-to-parallel converter.
package serial_to_parallel_pkg;

    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 32;

    // Counter width for a given word width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

    // Word bit index that receives serial bit number idx.
    function automatic int unsigned bit_pos(input int unsigned idx,
                                            input bit          msb_first,
                                            input int unsigned width);
        return msb_first ? (width - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/serial_to_parallel_word_slot.sv
// word_slot: one-deep output register holding a WIDTH-bit word behind a valid/ready handshake.
module word_slot
    import serial_to_parallel_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_word,
    output logic             o_valid,
    output logic             o_free
);

    logic [WIDTH-1:0] r_word;
    logic             r_valid;

    // A load may coincide with the consumer taking the current word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_word  = r_word;
    assign o_valid = r_valid;
    assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel converter: gathers WIDTH accepted bits into a word handed to word_slot.
module serial_to_parallel
    import serial_to_parallel_pkg::*;
#(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             I,
    input  logic             I_valid,
    output logic             I_ready,
    output logic [WIDTH-1:0] O,
    output logic             O_valid,
    input  logic             O_ready
);

    localparam int unsigned     CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST      = CW'(WIDTH - 1);
    localparam int unsigned     LAST_POS  = bit_pos(WIDTH - 1, MSB_FIRST, WIDTH);
    localparam int unsigned     SHIFT_OFF = MSB_FIRST ? 1 : 0;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-2:0] r_shift;

    logic             w_last;
    logic             w_slot_free;
    logic             w_accept;
    logic             w_load;
    logic [WIDTH-2:0] w_shift_nxt;
    logic [WIDTH-1:0] w_word;

    assign w_last   = (r_cnt == LAST);
    assign I_ready  = !(w_last && !w_slot_free);
    assign w_accept = I_valid && I_ready;
    assign w_load   = w_accept && w_last;

    // Shift slot k backs word bit k+SHIFT_OFF; the final bit never lands in the shift register.
    for (genvar k = 0; k < WIDTH - 1; k++) begin : g_shift
        assign w_shift_nxt[k] =
            (w_accept && !w_last &&
             bit_pos(32'(r_cnt), MSB_FIRST, WIDTH) == k + SHIFT_OFF) ? I : r_shift[k];
    end

    for (genvar j = 0; j < WIDTH; j++) begin : g_word
        if (j == LAST_POS) begin : g_in
            assign w_word[j] = I;
        end else begin : g_sr
            assign w_word[j] = r_shift[j - SHIFT_OFF];
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_shift <= w_shift_nxt;
            if (w_accept) begin
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end
        end
    end

    word_slot #(
        .WIDTH (WIDTH)
    ) u_slot (
        .i_clk   (CLK),
        .i_rst_n (ASYNCRESETN),
        .i_load  (w_load),
        .i_word  (w_word),
        .i_ready (O_ready),
        .o_word  (O),
        .o_valid (O_valid),
        .o_free  (w_slot_free)
    );

endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: directed scenarios plus randomized handshakes against a word-queue model.
module tb_serial_to_parallel;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_i = 1'b0, a_iv = 1'b0, a_or = 1'b1;
    logic       a_ir, a_ov;
    logic [1:0] a_o;

    logic       b_i = 1'b0, b_iv = 1'b0, b_or = 1'b1;
    logic       b_ir, b_ov;
    logic [7:0] b_o;

    always #5 clk = ~clk;

    serial_to_parallel #(.WIDTH(2), .MSB_FIRST(1'b0)) u_dut_a (
        .CLK (clk), .ASYNCRESETN (rst_n),
        .I (a_i), .I_valid (a_iv), .I_ready (a_ir),
        .O (a_o), .O_valid (a_ov), .O_ready (a_or)
    );

    serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_b (
        .CLK (clk), .ASYNCRESETN (rst_n),
        .I (b_i), .I_valid (b_iv), .I_ready (b_ir),
        .O (b_o), .O_valid (b_ov), .O_ready (b_or)
    );

    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model: bits gathered arithmetically, finished words queued until delivered.
    int          m_w;
    bit          m_msb;
    int          m_cnt;
    int          m_bits;
    int          m_words_made;
    int          obs_words;
    logic [31:0] m_acc;
    logic [31:0] m_q[$];
    logic        prev_stall;
    logic [31:0] prev_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int w, input bit msb);
        m_w          = w;
        m_msb        = msb;
        m_cnt        = 0;
        m_bits       = 0;
        m_words_made = 0;
        obs_words    = 0;
        m_acc        = '0;
        m_q.delete();
        prev_stall   = 1'b0;
        prev_o       = '0;
    endtask

    task automatic do_reset(input int w, input bit msb);
        @(negedge clk);
        a_iv = 1'b0; b_iv = 1'b0; a_or = 1'b1; b_or = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_a_ovalid", 32'(a_ov), 32'd0);
        chk("rst_a_o",      32'(a_o),  32'd0);
        chk("rst_a_iready", 32'(a_ir), 32'd1);
        chk("rst_b_ovalid", 32'(b_ov), 32'd0);
        chk("rst_b_o",      32'(b_o),  32'd0);
        chk("rst_b_iready", 32'(b_ir), 32'd1);
        #1 rst_n = 1'b1;
        model_reset(w, msb);
    endtask

    // One clock cycle on DUT d: drive at negedge, check, then advance the model past the posedge.
    task automatic step(input int d, input logic bi, input logic iv, input logic ordy);
        logic        ir, ov, exp_ir;
        logic [31:0] o;
        bit          acc, del;
        @(negedge clk);
        if (d == 0) begin
            a_i = bi; a_iv = iv; a_or = ordy; b_iv = 1'b0; b_or = 1'b1;
        end else begin
            b_i = bi; b_iv = iv; b_or = ordy; a_iv = 1'b0; a_or = 1'b1;
        end
        #1;
        ir = (d == 0) ? a_ir : b_ir;
        ov = (d == 0) ? a_ov : b_ov;
        o  = (d == 0) ? 32'(a_o) : 32'(b_o);
        exp_ir = !((m_cnt == m_w - 1) && (m_q.size() > 0) && !ordy);
        chk("i_ready", 32'(ir), 32'(exp_ir));
        chk("o_valid", 32'(ov), 32'(m_q.size() > 0));
        if (m_q.size() > 0) chk("o_word", o, m_q[0]);
        if (prev_stall && ov) chk("o_stable", o, prev_o);
        prev_stall = ov && !ordy;
        prev_o     = o;
        if (ov && ordy) obs_words++;
        acc = iv && exp_ir;
        del = ordy && (m_q.size() > 0);
        if (del) void'(m_q.pop_front());
        if (acc) begin
            m_bits++;
            m_acc = m_acc | (32'(bi) << (m_msb ? (m_w - 1 - m_cnt) : m_cnt));
            m_cnt++;
            if (m_cnt == m_w) begin
                m_q.push_back(m_acc);
                m_acc = '0;
                m_cnt = 0;
                m_words_made++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        #2;
        chk("init_a_ovalid", 32'(a_ov), 32'd0);
        chk("init_a_o",      32'(a_o),  32'd0);
        chk("init_a_iready", 32'(a_ir), 32'd1);
        chk("init_b_iready", 32'(b_ir), 32'd1);

        // Streaming 1,0,0,1 with W=2, LSB first.
        do_reset(2, 1'b0);
        step(0, 1'b1, 1'b1, 1'b1);
        step(0, 1'b0, 1'b1, 1'b1);
        step(0, 1'b0, 1'b1, 1'b1);
        chk("stream_w0_valid", 32'(a_ov), 32'd1);
        chk("stream_w0",       32'(a_o),  32'h1);
        step(0, 1'b1, 1'b1, 1'b1);
        chk("stream_gap_valid", 32'(a_ov), 32'd0);
        step(0, 1'b0, 1'b0, 1'b1);
        chk("stream_w1_valid", 32'(a_ov), 32'd1);
        chk("stream_w1",       32'(a_o),  32'h2);

        // Backpressure: word 11 held, bit 0 accepted, then bit 1 stalls.
        step(0, 1'b1, 1'b1, 1'b1);
        step(0, 1'b1, 1'b1, 1'b1);
        step(0, 1'b0, 1'b1, 1'b0);
        chk("bp_accept_ready", 32'(a_ir), 32'd1);
        step(0, 1'b1, 1'b1, 1'b0);
        chk("bp_stall_ready", 32'(a_ir), 32'd0);
        chk("bp_hold1",       32'(a_o),  32'h3);
        step(0, 1'b1, 1'b1, 1'b0);
        chk("bp_hold2",       32'(a_o),  32'h3);
        step(0, 1'b1, 1'b1, 1'b1);
        chk("bp_release_ready", 32'(a_ir), 32'd1);
        step(0, 1'b0, 1'b0, 1'b1);
        chk("bp_new_valid", 32'(a_ov), 32'd1);
        chk("bp_new_word",  32'(a_o),  32'h2);

        // Reset mid-word with a pending word, then a fresh word 1,0.
        step(0, 1'b1, 1'b1, 1'b1);
        step(0, 1'b1, 1'b1, 1'b1);
        step(0, 1'b0, 1'b1, 1'b0);
        do_reset(2, 1'b0);
        step(0, 1'b1, 1'b1, 1'b1);
        step(0, 1'b0, 1'b1, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_valid", 32'(a_ov), 32'd1);
        chk("post_rst_word",  32'(a_o),  32'h1);

        // W=8, MSB first: 1,0,1,1,0,0,0,1 -> 8'hB1 in cycle 9.
        do_reset(8, 1'b1);
        pat = 8'b1011_0001;
        for (int i = 7; i >= 0; i--) step(1, pat[i], 1'b1, 1'b1);
        step(1, 1'b0, 1'b0, 1'b1);
        chk("msb8_valid", 32'(b_ov), 32'd1);
        chk("msb8_word",  32'(b_o),  32'hB1);

        // Randomized valid/ready gaps, 1000 bits per instance.
        for (int d = 0; d < 2; d++) begin
            if (d == 0) do_reset(2, 1'b0);
            else        do_reset(8, 1'b1);
            for (int c = 0; c < 20000 && m_bits < 1000; c++)
                step(d, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            for (int c = 0; c < 4 && m_q.size() > 0; c++)
                step(d, 1'b0, 1'b0, 1'b1);
            chk("rand_words_delivered", 32'(obs_words), 32'(m_words_made));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 SHALL have parameter WIDTH, default 2: number of serial bits per output word; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 means the first accepted bit lands in O[0]; 1 means it lands in O[WIDTH-1].
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port ASYNCRESETN, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port I, input, 1 bit: serial data bit.
REQ-006 SHALL have port I_valid, input, 1 bit: I carries a bit this cycle.
REQ-007 SHALL have port I_ready, output, 1 bit: the block accepts I this cycle.
REQ-008 SHALL have port O, output, WIDTH bits: assembled parallel word.
REQ-009 SHALL have port O_valid, output, 1 bit: O holds a complete word.
REQ-010 SHALL have port O_ready, input, 1 bit: the consumer takes O this cycle.

Function
REQ-011 SHALL accept a bit exactly in a cycle where I_valid and I_ready are both 1 (input handshake).
REQ-012 SHALL deliver a word exactly in a cycle where O_valid and O_ready are both 1 (output handshake).
REQ-013 SHALL keep a bit counter (0..WIDTH-1) and a shift register of WIDTH-1 bits; each accepted bit is stored at the position given by the counter and MSB_FIRST, then the counter increments.
REQ-014 SHALL, when the bit accepted has counter equal to WIDTH-1, load the complete WIDTH-bit word into the output register, set O_valid, and wrap the counter to 0, all in the same edge.
REQ-015 SHALL assert O_valid starting the cycle after the WIDTH-th bit of a word is accepted (latency 1 cycle).
REQ-016 SHALL hold O and O_valid stable while O_valid=1 and O_ready=0.
REQ-017 SHALL clear O_valid after an output handshake unless a new word loads on the same edge, in which case O_valid stays 1 and O takes the new word.
REQ-018 SHALL drive I_ready=0 only when the counter equals WIDTH-1, O_valid=1 and O_ready=0; otherwise I_ready=1.
REQ-019 SHALL allow I_ready to depend combinationally on O_ready (the only comb path); no path SHALL exist from I_valid to O_valid, O or I_ready.
REQ-020 SHALL keep accepting bits 0..WIDTH-2 of the next word while a full word waits in the output register.
REQ-021 SHALL sustain one word every WIDTH cycles with I_valid=1 and O_ready=1 held constant, with no bubble cycles.
REQ-022 SHALL ignore I whenever no input handshake occurs; the counter and shift register SHALL remain unchanged.
REQ-023 SHALL leave O at its last loaded value after an output handshake; O is don't-care for the consumer while O_valid=0.

Reset
REQ-024 SHALL, while ASYNCRESETN=0, immediately force the counter to 0, the shift register to 0, O to 0 and O_valid to 0, independent of CLK.
REQ-025 SHALL drive I_ready=1 during and after reset.
REQ-026 SHALL discard any partially assembled word and any undelivered word when reset occurs mid-operation; the first bit accepted after reset release is bit 0 of a new word.

Structure
REQ-027 SHALL place the counter width constant ($clog2(WIDTH), minimum 1) and the bit-position function (counter index and MSB_FIRST to bit index) in a shared package serial_to_parallel_pkg.
REQ-028 SHALL implement the output register and O_valid logic as one sub-module, word_slot, which holds one WIDTH-bit word with a valid/ready handshake.
REQ-029 SHALL keep the counter and shift register in the top module.

Verification
REQ-030 Bench SHALL apply reset mid-word (WIDTH=2, one bit accepted, then ASYNCRESETN=0 between edges) and check that O_valid and O clear immediately, I_ready=1, and that the next two bits 1,0 give O=2'b01.
REQ-031 Bench SHALL stream bits 1,0,0,1 with WIDTH=2, MSB_FIRST=0, I_valid=1 and O_ready=1, and check O=2'b01 then O=2'b10, each O_valid pulse one cycle after the second bit.
REQ-032 Bench SHALL stream bits 1,0,1,1,0,0,0,1 with WIDTH=8 and MSB_FIRST=1, and check O=8'hB1 with O_valid=1 in cycle 9.
REQ-033 Bench SHALL apply backpressure (WIDTH=2, O_ready=0 after the first word) and check that one more bit is accepted, that I_ready then goes to 0, and that O stays stable; then raise O_ready=1 and check that the stalled bit is accepted in the same cycle and the new word appears without O_valid dropping.
REQ-034 Bench SHALL apply random I_valid and O_ready gaps over 1000 bits against a reference queue, and check that the words match, none are lost or duplicated, and O is stable while O_valid=1 and O_ready=0.
